// File: rtl/wb_arbiter_2m.sv
// ---------------------------------------------------------------------------
// wb_arbiter_2m
//
// Shares one classic (single-transfer) Wishbone slave between two masters:
// M0 (core data port) and M1 (instruction fetch). One master owns the slave
// for its whole cyc window. When both ask from an idle bus, the one that was
// not granted most recently wins. A per-transfer watchdog returns an error
// pulse to a master whose strobed transfer is never acknowledged.
//
// Handshake: a master requests with cyc & stb; a transfer completes in the
// cycle the slave raises ack while the owning master still holds stb. The
// master must keep adr/dat/we stable until it sees ack (or err). Ack and err
// are single-cycle pulses and are only ever given to the owning master.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mN_wb_adr_i/dat_i/we_i   master N request fields
//   mN_wb_stb_i/cyc_i        master N strobe / cycle
//   mN_wb_dat_o              read data (0 unless master N owns the bus)
//   mN_wb_ack_o/err_o        acknowledge / watchdog error pulse
//   s_wb_*_o                 request forwarded to the slave (0 when idle)
//   s_wb_dat_i, s_wb_ack_i   slave read data / acknowledge
//   gnt_o                    one-hot owner: bit0 = M0, bit1 = M1, 0 idle
//   dbg_state                current arbiter state for observation
// ---------------------------------------------------------------------------
module wb_arbiter_2m #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] m0_wb_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_wb_dat_i,
    input  logic                  m0_wb_we_i,
    input  logic                  m0_wb_stb_i,
    input  logic                  m0_wb_cyc_i,
    output logic [DATA_WIDTH-1:0] m0_wb_dat_o,
    output logic                  m0_wb_ack_o,
    output logic                  m0_wb_err_o,

    input  logic [ADDR_WIDTH-1:0] m1_wb_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_wb_dat_i,
    input  logic                  m1_wb_we_i,
    input  logic                  m1_wb_stb_i,
    input  logic                  m1_wb_cyc_i,
    output logic [DATA_WIDTH-1:0] m1_wb_dat_o,
    output logic                  m1_wb_ack_o,
    output logic                  m1_wb_err_o,

    output logic [ADDR_WIDTH-1:0] s_wb_adr_o,
    output logic [DATA_WIDTH-1:0] s_wb_dat_o,
    output logic                  s_wb_we_o,
    output logic                  s_wb_stb_o,
    output logic                  s_wb_cyc_o,
    input  logic [DATA_WIDTH-1:0] s_wb_dat_i,
    input  logic                  s_wb_ack_i,

    output logic [1:0]            gnt_o,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_M0 = 2'd1,
        BUSY_M1 = 2'd2
    } state_t;

    // A zero TIMEOUT still needs a legal (1-bit) counter; it simply never counts.
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    state_t          state;
    state_t          state_next;
    state_t          cur;          // state as seen by the outputs
    logic            last_gnt;     // 0 = M0 granted last, 1 = M1
    logic            last_gnt_next;
    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_cnt_next;
    logic            req0;
    logic            req1;
    logic            owner_stb;
    logic            owner_cyc;
    logic            wd_fire;

    assign req0 = m0_wb_cyc_i & m0_wb_stb_i;
    assign req1 = m1_wb_cyc_i & m1_wb_stb_i;

    // Reset takes effect on the outputs in the cycle it is asserted, so an
    // aborted owner never sees a late ack and the slave strobe drops at once.
    assign cur       = rst ? IDLE : state;
    assign dbg_state = state;

    always_comb begin
        owner_stb = 1'b0;
        owner_cyc = 1'b0;
        case (state)
            BUSY_M0: begin
                owner_stb = m0_wb_stb_i;
                owner_cyc = m0_wb_cyc_i;
            end
            BUSY_M1: begin
                owner_stb = m1_wb_stb_i;
                owner_cyc = m1_wb_cyc_i;
            end
            default: ;
        endcase
    end

    // Expiry only counts when the slave is not acking in the same cycle.
    always_comb begin
        wd_fire = 1'b0;
        if (TIMEOUT > 0 && state != IDLE && wd_cnt == WD_MAX && !s_wb_ack_i) begin
            wd_fire = 1'b1;
        end
    end

    always_comb begin
        state_next    = state;
        last_gnt_next = last_gnt;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || last_gnt)) begin
                    state_next    = BUSY_M0;
                    last_gnt_next = 1'b0;
                end else if (req1) begin
                    state_next    = BUSY_M1;
                    last_gnt_next = 1'b1;
                end
            end
            // Ownership always passes through IDLE, never straight across.
            BUSY_M0, BUSY_M1: begin
                if (!owner_cyc || wd_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counts strobed, un-acked cycles of the current owner; any ack, idle
    // cycle or change of owner starts it over.
    always_comb begin
        wd_cnt_next = '0;
        if (TIMEOUT > 0 && state != IDLE && state_next == state && !s_wb_ack_i) begin
            wd_cnt_next = owner_stb ? wd_cnt + WD_W'(1) : wd_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            wd_cnt   <= '0;
        end else begin
            state    <= state_next;
            last_gnt <= last_gnt_next;
            wd_cnt   <= wd_cnt_next;
        end
    end

    always_comb begin
        s_wb_adr_o  = '0;
        s_wb_dat_o  = '0;
        s_wb_we_o   = 1'b0;
        s_wb_stb_o  = 1'b0;
        s_wb_cyc_o  = 1'b0;
        m0_wb_dat_o = '0;
        m0_wb_ack_o = 1'b0;
        m0_wb_err_o = 1'b0;
        m1_wb_dat_o = '0;
        m1_wb_ack_o = 1'b0;
        m1_wb_err_o = 1'b0;
        gnt_o       = 2'b00;
        case (cur)
            BUSY_M0: begin
                s_wb_adr_o  = m0_wb_adr_i;
                s_wb_dat_o  = m0_wb_dat_i;
                s_wb_we_o   = m0_wb_we_i;
                s_wb_stb_o  = m0_wb_stb_i;
                s_wb_cyc_o  = m0_wb_cyc_i;
                m0_wb_dat_o = s_wb_dat_i;
                // Gating on stb hides the slave's trailing ack after stb drops.
                m0_wb_ack_o = m0_wb_stb_i & s_wb_ack_i;
                m0_wb_err_o = wd_fire;
                gnt_o       = 2'b01;
            end
            BUSY_M1: begin
                s_wb_adr_o  = m1_wb_adr_i;
                s_wb_dat_o  = m1_wb_dat_i;
                s_wb_we_o   = m1_wb_we_i;
                s_wb_stb_o  = m1_wb_stb_i;
                s_wb_cyc_o  = m1_wb_cyc_i;
                m1_wb_dat_o = s_wb_dat_i;
                m1_wb_ack_o = m1_wb_stb_i & s_wb_ack_i;
                m1_wb_err_o = wd_fire;
                gnt_o       = 2'b10;
            end
            default: ;
        endcase
    end

endmodule
